tow_round_ctrl: RTL and testbench
=================================

Name: tow_round_ctrl

Overview:
- Round controller for the Tug-of-War game. Sits directly upstream of the LED output mux.
- Turns single-cycle player press pulses and a start pulse into a rope position. Drives the 7-bit score bus and the 2-bit LED control code that the mux consumes.
- Also reports the round winner to the status/7-seg logic.

Parameters:
- DARK_CYCLES, 50_000_000: length of the dark "get ready" phase in clock cycles (1 s at 50 MHz). Must be >= 2.
- BLINK_CYCLES, 12_500_000: half-period of the winner blink, in cycles. Must be >= 1.
- CNT_W, 26: width of the shared phase counter. Must hold max(DARK_CYCLES, BLINK_CYCLES).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new round.
- pl  in  1  left-player press, debounced, single-cycle pulse.
- pr  in  1  right-player press, debounced, single-cycle pulse.
- score  out  7  one-hot rope position; bit 6 is the left end, bit 0 the right end.
- led_ctrl  out  2  LED mux code: 11 = reset pattern, 10 = show score, 00 = dark. Code 01 is never driven.
- winner  out  2  00 = none, 10 = left won, 01 = right won.

Behaviour:
- All outputs are registered. Reset values: state S_RST, pos = 3, score = 7'b0001000, led_ctrl = 11, winner = 00, counter = 0. Reset takes effect immediately, mid-round or at any point.
- pos is a 3-bit value in the range 0..6. score = 1 << pos, updated on the same edge as pos, so score is never zero and never multi-hot.
- Latency: an input sampled at edge N produces new outputs after edge N. There are no combinational paths from inputs to outputs.
- start has priority over pl/pr in every state. On start: state S_DARK, pos = 3, counter = 0, winner = 00, led_ctrl = 00.
- S_RST:
  - led_ctrl = 11. pl and pr are ignored.
  - Exits only on start.
- S_DARK:
  - led_ctrl = 00. counter increments each cycle.
  - A pl or pr pulse (false start) clears counter to 0 and keeps the state; pos stays 3.
  - When counter reaches DARK_CYCLES-1 with no press that cycle: go to S_PLAY, counter = 0, led_ctrl = 10.
- S_PLAY:
  - led_ctrl = 10.
  - pl alone: pos + 1. pr alone: pos - 1. pl and pr in the same cycle: no change.
  - If the updated pos is 6: winner = 10 and go to S_WIN on the same edge.
  - If the updated pos is 0: winner = 01 and go to S_WIN on the same edge.
  - pos never goes beyond 0..6, because S_PLAY is left when an end is reached.
- S_WIN:
  - score holds the end position. pl and pr are ignored.
  - counter counts 0..BLINK_CYCLES-1 and then wraps to 0. On each wrap, led_ctrl toggles between 10 and 00, starting at 10 on entry.
  - winner is held until start or rst.
- Counter: cleared on every state entry and never overflows, because of the terminal compares above.

Test Plan:
- Reset: assert rst mid-S_PLAY with pos = 5 -> immediately score = 0001000, led_ctrl = 11, winner = 00; after release, pl/pr pulses cause no change.
- Dark phase (DARK_CYCLES = 8): start pulse -> led_ctrl = 00 for exactly 8 cycles, then led_ctrl = 10 and score = 0001000.
- False start (DARK_CYCLES = 8): pr at dark cycle 5 -> dark lasts 5 + 8 cycles in total; pos remains 3.
- Play:
  - 3 × pl -> score steps 0010000, 0100000, 1000000; winner = 10 on the third pulse's edge; state S_WIN.
  - Simultaneous pl+pr at pos 3 -> score unchanged.
- Right win and blink (BLINK_CYCLES = 4): 3 × pr from centre -> score = 0000001, winner = 01; led_ctrl alternates 10 for 4 cycles, 00 for 4 cycles; further pl pulses are ignored.
- Start priority: start coincident with pl during S_PLAY at pos 4 -> S_DARK, pos = 3, winner = 00, led_ctrl = 00.

Source files
------------

// File: rtl/tow_round_ctrl.sv
// Tug-of-War round controller.
// Turns start and player press pulses into a one-hot rope position, the
// LED mux control code and the round winner. Every output is registered.
module tow_round_ctrl #(
    parameter int DARK_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pl,
    input  logic       pr,
    output logic [6:0] score,
    output logic [1:0] led_ctrl,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {S_RST, S_DARK, S_PLAY, S_WIN} state_t;

    localparam logic [CNT_W-1:0] DARK_LAST  = CNT_W'(DARK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

    localparam logic [1:0] LED_RST  = 2'b11;
    localparam logic [1:0] LED_SHOW = 2'b10;
    localparam logic [1:0] LED_DARK = 2'b00;

    state_t           state;
    logic [2:0]       pos;
    logic [2:0]       pos_step;
    logic [CNT_W-1:0] cnt;

    // Rope position after this cycle's presses; a simultaneous pair cancels.
    // The end guards are redundant with leaving S_PLAY at 0/6 but keep pos in range.
    always_comb begin
        pos_step = pos;
        if (pl && !pr && pos != 3'd6)
            pos_step = pos + 3'd1;
        else if (pr && !pl && pos != 3'd0)
            pos_step = pos - 3'd1;
    end

    // Round FSM; start wins over everything except reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RST;
            pos      <= 3'd3;
            score    <= 7'b0001000;
            led_ctrl <= LED_RST;
            winner   <= 2'b00;
            cnt      <= '0;
        end else if (start) begin
            state    <= S_DARK;
            pos      <= 3'd3;
            score    <= 7'b0001000;
            led_ctrl <= LED_DARK;
            winner   <= 2'b00;
            cnt      <= '0;
        end else begin
            case (state)
                S_RST: ;
                S_DARK: begin
                    // A press during the dark phase restarts the wait.
                    if (pl || pr) begin
                        cnt <= '0;
                    end else if (cnt == DARK_LAST) begin
                        state    <= S_PLAY;
                        cnt      <= '0;
                        led_ctrl <= LED_SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    pos   <= pos_step;
                    score <= 7'd1 << pos_step;
                    if (pos_step == 3'd6) begin
                        winner   <= 2'b10;
                        state    <= S_WIN;
                        cnt      <= '0;
                        led_ctrl <= LED_SHOW;
                    end else if (pos_step == 3'd0) begin
                        winner   <= 2'b01;
                        state    <= S_WIN;
                        cnt      <= '0;
                        led_ctrl <= LED_SHOW;
                    end
                end
                S_WIN: begin
                    // Blink the winning end: toggle show/dark every BLINK_CYCLES.
                    if (cnt == BLINK_LAST) begin
                        cnt      <= '0;
                        led_ctrl <= (led_ctrl == LED_SHOW) ? LED_DARK : LED_SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Directed bench for tow_round_ctrl with short dark/blink phases.
module tb_tow_round_ctrl;

    localparam int DARK  = 8;
    localparam int BLINK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pl = 1'b0;
    logic       pr = 1'b0;
    logic [6:0] score;
    logic [1:0] led_ctrl;
    logic [1:0] winner;

    int ntest = 0;
    int nfail = 0;

    tow_round_ctrl #(.DARK_CYCLES(DARK), .BLINK_CYCLES(BLINK), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pl(pl), .pr(pr),
        .score(score), .led_ctrl(led_ctrl), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, pl, pr;
        logic [6:0] score;
        logic [1:0] led, win;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [6:0] s, input logic [1:0] l, input logic [1:0] w);
        chk({nm, ".score"}, 32'(score), 32'(s));
        chk({nm, ".led"}, 32'(led_ctrl), 32'(l));
        chk({nm, ".win"}, 32'(winner), 32'(w));
    endtask

    // Drive inputs between edges, then sample just after the next rising edge.
    task automatic step(input logic s, input logic l, input logic r);
        @(negedge clk);
        start = s; pl = l; pr = r;
        @(posedge clk);
        #1;
    endtask

    // Call right after the start edge; counts cycles with led_ctrl = 00.
    // A pr pulse is injected on the edge numbered pr_at (0 = never).
    task automatic dark_len(input int pr_at, output int n);
        n = 0;
        while (led_ctrl == 2'b00 && n < 60) begin
            n++;
            step(1'b0, 1'b0, (n == pr_at));
        end
    endtask

    initial begin
        int n;
        vt[0] = '{1'b0, 1'b1, 1'b1, 7'b0001000, 2'b10, 2'b00};
        vt[1] = '{1'b0, 1'b1, 1'b0, 7'b0010000, 2'b10, 2'b00};
        vt[2] = '{1'b0, 1'b0, 1'b1, 7'b0001000, 2'b10, 2'b00};
        vt[3] = '{1'b0, 1'b0, 1'b0, 7'b0001000, 2'b10, 2'b00};
        vt[4] = '{1'b0, 1'b1, 1'b0, 7'b0010000, 2'b10, 2'b00};
        vt[5] = '{1'b0, 1'b1, 1'b0, 7'b0100000, 2'b10, 2'b00};
        vt[6] = '{1'b0, 1'b1, 1'b0, 7'b1000000, 2'b10, 2'b10};
        vt[7] = '{1'b0, 1'b1, 1'b0, 7'b1000000, 2'b10, 2'b10};
        vt[8] = '{1'b0, 1'b0, 1'b1, 7'b1000000, 2'b10, 2'b10};
        vt[9] = '{1'b1, 1'b1, 1'b0, 7'b0001000, 2'b00, 2'b00};

        // Reset state, then presses are ignored in S_RST.
        #12;
        chk_out("reset", 7'b0001000, 2'b11, 2'b00);
        @(negedge clk) rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk_out("rst_pl", 7'b0001000, 2'b11, 2'b00);
        step(1'b0, 1'b0, 1'b1);
        chk_out("rst_pr", 7'b0001000, 2'b11, 2'b00);

        // Start with a coincident pl: start wins, dark phase is DARK cycles.
        step(1'b1, 1'b1, 1'b0);
        chk_out("start", 7'b0001000, 2'b00, 2'b00);
        dark_len(0, n);
        chk("dark_len", 32'(n), 32'(DARK));
        chk_out("play_entry", 7'b0001000, 2'b10, 2'b00);

        // Play table: tie, moves, left win, ignored presses, restart.
        for (int i = 0; i < 10; i++) begin
            step(vt[i].start, vt[i].pl, vt[i].pr);
            chk_out($sformatf("vec%0d", i), vt[i].score, vt[i].led, vt[i].win);
        end

        // False start: pr on the 5th dark edge restarts the wait.
        dark_len(5, n);
        chk("false_start_len", 32'(n), 32'(5 + DARK));
        chk_out("false_start_pos", 7'b0001000, 2'b10, 2'b00);

        // Start priority in S_PLAY at pos 4.
        step(1'b0, 1'b1, 1'b0);
        chk_out("pos4", 7'b0010000, 2'b10, 2'b00);
        step(1'b1, 1'b1, 1'b0);
        chk_out("start_prio", 7'b0001000, 2'b00, 2'b00);
        dark_len(0, n);
        chk("dark_len2", 32'(n), 32'(DARK));

        // Right win, then blink with ignored pl pulses.
        step(1'b0, 1'b0, 1'b1);
        chk_out("r1", 7'b0000100, 2'b10, 2'b00);
        step(1'b0, 1'b0, 1'b1);
        chk_out("r2", 7'b0000010, 2'b10, 2'b00);
        step(1'b0, 1'b0, 1'b1);
        chk_out("r3", 7'b0000001, 2'b10, 2'b01);
        for (int k = 1; k < 17; k++) begin
            step(1'b0, k[0], 1'b0);
            chk_out($sformatf("blink%0d", k), 7'b0000001,
                    (((k / BLINK) % 2) == 0) ? 2'b10 : 2'b00, 2'b01);
        end

        // Asynchronous reset mid-play at pos 5.
        step(1'b1, 1'b0, 1'b0);
        dark_len(0, n);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_out("pos5", 7'b0100000, 2'b10, 2'b00);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 7'b0001000, 2'b11, 2'b00);
        @(negedge clk) rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk_out("post_rst_pl", 7'b0001000, 2'b11, 2'b00);
        step(1'b0, 1'b0, 1'b1);
        chk_out("post_rst_pr", 7'b0001000, 2'b11, 2'b00);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
